prefetch_queue_ctrl: RTL and testbench

- Bus-interface fetch controller for the 8086 core. It sequences byte-wide reads from the instruction ROM into a 6-byte prefetch queue.
- The queue is exposed to the decode/execute logic, which consumes 1-6 bytes per instruction.
- Jumps, calls and interrupts flush the queue and redirect fetch to a new CS:IP.
- Fetching pauses while the execution unit owns the bus.

---
 rtl/prefetch_queue_ctrl.sv | 99 +++++++++
 tb/tb_prefetch_queue_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue_ctrl.sv
// 8086 prefetch queue controller.
// Sequences byte fetches from ROM into a 6-byte queue.
module prefetch_queue_ctrl #(
  parameter int          QDEPTH   = 6,
  parameter logic [15:0] RESET_CS = 16'hFFFF,
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rom_en,
  output logic [19:0]           rom_addr,
  input  logic [7:0]            rom_data,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [15:0]           flush_cs,
  input  logic [15:0]           flush_ip,
  input  logic                  consume,
  input  logic [2:0]            consume_n,
  output logic [QDEPTH*8-1:0]   q_bytes,
  output logic [2:0]            q_count,
  output logic [15:0]           head_ip,
  output logic [15:0]           cs_out
);

  logic [QDEPTH*8-1:0] q_r;
  logic [QDEPTH*8-1:0] q_nxt;
  logic [2:0]          cnt;
  logic [2:0]          cnt_nxt;
  logic [2:0]          n_cons;
  logic [2:0]          slot;
  logic [15:0]         cs_r;
  logic [15:0]         fetch_ip;
  logic [15:0]         head_r;
  logic [19:0]         phys;
  logic [3:0]          occ;
  logic                pending;
  logic                discard;
  logic                issue;
  logic                take;
  logic                capture;

  // Issue decision and physical fetch address from registered state.
  always_comb begin
    occ      = {1'b0, cnt} + {3'b000, pending};
    issue    = rst && !flush && !stall && (occ < 4'(QDEPTH));
    phys     = {cs_r, 4'b0000} + {4'b0000, fetch_ip};
    rom_en   = issue;
    rom_addr = issue ? phys : 20'h00000;
  end

  // Next queue image: shift out consumed bytes, drop in the returning byte.
  always_comb begin
    take    = consume && (consume_n != 3'd0) && (consume_n <= cnt);
    n_cons  = take ? consume_n : 3'd0;
    capture = pending && !discard;
    slot    = cnt - n_cons;
    q_nxt   = q_r >> {n_cons, 3'b000};
    for (int i = 0; i < QDEPTH; i++) begin
      if (capture && (slot == 3'(i))) begin
        q_nxt[i*8 +: 8] = rom_data;
      end
    end
    cnt_nxt = slot + {2'b00, capture};
  end

  // State update; flush outranks consume, stall and data return.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_r      <= '0;
      cnt      <= 3'd0;
      pending  <= 1'b0;
      discard  <= 1'b0;
      cs_r     <= RESET_CS;
      fetch_ip <= RESET_IP;
      head_r   <= RESET_IP;
    end else if (flush) begin
      q_r      <= '0;
      cnt      <= 3'd0;
      pending  <= 1'b0;
      discard  <= pending;
      cs_r     <= flush_cs;
      fetch_ip <= flush_ip;
      head_r   <= flush_ip;
    end else begin
      q_r      <= q_nxt;
      cnt      <= cnt_nxt;
      pending  <= issue;
      discard  <= 1'b0;
      fetch_ip <= fetch_ip + {15'd0, issue};
      head_r   <= head_r + {13'd0, n_cons};
    end
  end

  assign q_bytes = q_r;
  assign q_count = cnt;
  assign head_ip = head_r;
  assign cs_out  = cs_r;

endmodule

// File: tb/tb_prefetch_queue_ctrl.sv
// Directed bench for prefetch_queue_ctrl.
// ROM returns (addr[7:0] + 8'h21) one cycle after rom_en.
module tb_prefetch_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_en;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data = 8'hEE;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] flush_cs = 16'h0;
  logic [15:0] flush_ip = 16'h0;
  logic        consume = 1'b0;
  logic [2:0]  consume_n = 3'd0;
  logic [47:0] q_bytes;
  logic [2:0]  q_count;
  logic [15:0] head_ip;
  logic [15:0] cs_out;

  int errors = 0;
  int checks = 0;

  prefetch_queue_ctrl dut (
    .clk(clk), .rst(rst),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .stall(stall), .flush(flush),
    .flush_cs(flush_cs), .flush_ip(flush_ip),
    .consume(consume), .consume_n(consume_n),
    .q_bytes(q_bytes), .q_count(q_count),
    .head_ip(head_ip), .cs_out(cs_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    rom_data <= rom_en ? rom_addr[7:0] + 8'h21 : 8'hEE;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (rom_en !== 1'b0) begin
      errors++; $display("FAIL rst_rom_en got %b want 0", rom_en);
    end
    checks++;
    if (rom_addr !== 20'h0) begin
      errors++; $display("FAIL rst_addr got %h want 00000", rom_addr);
    end
    checks++;
    if ({q_count, q_bytes} !== 51'h0) begin
      errors++; $display("FAIL rst_queue got %0d/%h want 0/0", q_count, q_bytes);
    end
    checks++;
    if ({cs_out, head_ip} !== 32'hFFFF_0000) begin
      errors++; $display("FAIL rst_csip got %h:%h want FFFF:0000", cs_out, head_ip);
    end
  endtask

  task automatic test_fill();
    rst = 1'b1;
    #1;
    checks++;
    if ({rom_en, rom_addr} !== {1'b1, 20'hFFFF0}) begin
      errors++; $display("FAIL fill_addr0 got %b/%h want 1/FFFF0", rom_en, rom_addr);
    end
    for (int i = 1; i < 6; i++) begin
      tick();
      #1;
      checks++;
      if ({rom_en, rom_addr} !== {1'b1, 20'hFFFF0 + 20'(i)}) begin
        errors++;
        $display("FAIL fill_addr%0d got %b/%h want 1/%h", i, rom_en, rom_addr, 20'hFFFF0 + 20'(i));
      end
    end
    tick();
    #1;
    checks++;
    if ({rom_en, q_count} !== {1'b0, 3'd5}) begin
      errors++; $display("FAIL fill_edge6 got en=%b cnt=%0d want en=0 cnt=5", rom_en, q_count);
    end
    tick();
    #1;
    checks++;
    if ({rom_en, q_count} !== {1'b0, 3'd6}) begin
      errors++; $display("FAIL fill_edge7 got en=%b cnt=%0d want en=0 cnt=6", rom_en, q_count);
    end
    checks++;
    if (q_bytes !== 48'h161514131211) begin
      errors++; $display("FAIL fill_bytes got %h want 161514131211", q_bytes);
    end
    checks++;
    if (head_ip !== 16'h0000) begin
      errors++; $display("FAIL fill_head got %h want 0000", head_ip);
    end
  endtask

  task automatic test_consume();
    consume = 1'b1;
    consume_n = 3'd3;
    tick();
    consume = 1'b0;
    #1;
    checks++;
    if ({q_count, q_bytes} !== {3'd3, 48'h000000161514}) begin
      errors++; $display("FAIL cons3_queue got %0d/%h want 3/000000161514", q_count, q_bytes);
    end
    checks++;
    if (head_ip !== 16'h0003) begin
      errors++; $display("FAIL cons3_head got %h want 0003", head_ip);
    end
    checks++;
    if ({rom_en, rom_addr} !== {1'b1, 20'hFFFF6}) begin
      errors++; $display("FAIL cons3_refetch got %b/%h want 1/FFFF6", rom_en, rom_addr);
    end
    repeat (4) tick();
    #1;
    checks++;
    if ({q_count, q_bytes} !== {3'd6, 48'h191817161514}) begin
      errors++; $display("FAIL refill got %0d/%h want 6/191817161514", q_count, q_bytes);
    end
  endtask

  task automatic test_flush_pending();
    consume = 1'b1;
    consume_n = 3'd1;
    tick();
    consume = 1'b0;
    #1;
    checks++;
    if ({q_count, rom_en, rom_addr} !== {3'd5, 1'b1, 20'hFFFF9}) begin
      errors++; $display("FAIL pre_flush got %0d/%b/%h want 5/1/FFFF9", q_count, rom_en, rom_addr);
    end
    tick();
    flush = 1'b1;
    flush_cs = 16'h1000;
    flush_ip = 16'h0020;
    #1;
    checks++;
    if (rom_en !== 1'b0) begin
      errors++; $display("FAIL flush_cycle_en got %b want 0", rom_en);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({q_count, cs_out, head_ip} !== {3'd0, 16'h1000, 16'h0020}) begin
      errors++; $display("FAIL flush_state got %0d %h:%h want 0 1000:0020", q_count, cs_out, head_ip);
    end
    checks++;
    if ({rom_en, rom_addr} !== {1'b1, 20'h10020}) begin
      errors++; $display("FAIL flush_addr got %b/%h want 1/10020", rom_en, rom_addr);
    end
    tick();
    #1;
    checks++;
    if ({q_count, rom_addr} !== {3'd0, 20'h10021}) begin
      errors++; $display("FAIL flush_discard got %0d/%h want 0/10021", q_count, rom_addr);
    end
    tick();
    #1;
    checks++;
    if ({q_count, q_bytes[7:0]} !== {3'd1, 8'h41}) begin
      errors++; $display("FAIL flush_first got %0d/%h want 1/41", q_count, q_bytes[7:0]);
    end
  endtask

  task automatic test_wrap();
    flush = 1'b1;
    flush_cs = 16'h0000;
    flush_ip = 16'hFFFF;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({rom_en, rom_addr} !== {1'b1, 20'h0FFFF}) begin
      errors++; $display("FAIL wrap_off0 got %b/%h want 1/0FFFF", rom_en, rom_addr);
    end
    tick();
    #1;
    checks++;
    if ({rom_en, rom_addr} !== {1'b1, 20'h00000}) begin
      errors++; $display("FAIL wrap_off1 got %b/%h want 1/00000", rom_en, rom_addr);
    end
    flush = 1'b1;
    flush_cs = 16'hFFFF;
    flush_ip = 16'h0010;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({rom_en, rom_addr, cs_out, head_ip} !== {1'b1, 20'h00000, 16'hFFFF, 16'h0010}) begin
      errors++;
      $display("FAIL wrap_1m got %b/%h %h:%h want 1/00000 FFFF:0010", rom_en, rom_addr, cs_out, head_ip);
    end
  endtask

  task automatic test_stall();
    flush = 1'b1;
    flush_cs = 16'h2000;
    flush_ip = 16'h0100;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({rom_en, rom_addr} !== {1'b1, 20'h20100}) begin
      errors++; $display("FAIL stall_pre got %b/%h want 1/20100", rom_en, rom_addr);
    end
    tick();
    stall = 1'b1;
    #1;
    checks++;
    if (rom_en !== 1'b0) begin
      errors++; $display("FAIL stall_en0 got %b want 0", rom_en);
    end
    tick();
    #1;
    checks++;
    if ({rom_en, q_count, q_bytes} !== {1'b0, 3'd1, 48'h21}) begin
      errors++; $display("FAIL stall_capture got %b/%0d/%h want 0/1/21", rom_en, q_count, q_bytes);
    end
    tick();
    stall = 1'b0;
    #1;
    checks++;
    if ({rom_en, rom_addr} !== {1'b1, 20'h20101}) begin
      errors++; $display("FAIL stall_resume got %b/%h want 1/20101", rom_en, rom_addr);
    end
  endtask

  task automatic test_bad_consume();
    tick();
    stall = 1'b1;
    tick();
    consume = 1'b1;
    consume_n = 3'd4;
    #1;
    checks++;
    if (q_count !== 3'd2) begin
      errors++; $display("FAIL bad_pre got %0d want 2", q_count);
    end
    tick();
    consume_n = 3'd0;
    #1;
    checks++;
    if ({q_count, q_bytes, head_ip} !== {3'd2, 48'h2221, 16'h0100}) begin
      errors++; $display("FAIL cons_gt got %0d/%h/%h want 2/2221/0100", q_count, q_bytes, head_ip);
    end
    tick();
    consume = 1'b0;
    stall = 1'b0;
    #1;
    checks++;
    if ({q_count, q_bytes, head_ip} !== {3'd2, 48'h2221, 16'h0100}) begin
      errors++; $display("FAIL cons_zero got %0d/%h/%h want 2/2221/0100", q_count, q_bytes, head_ip);
    end
  endtask

  task automatic test_back_to_back();
    flush = 1'b1;
    flush_cs = 16'h3000;
    flush_ip = 16'h0000;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    #1;
    checks++;
    if ({q_count, rom_en} !== {3'd5, 1'b0}) begin
      errors++; $display("FAIL b2b_pre got %0d/%b want 5/0", q_count, rom_en);
    end
    consume = 1'b1;
    consume_n = 3'd1;
    tick();
    consume = 1'b0;
    #1;
    checks++;
    if ({q_count, q_bytes} !== {3'd5, 48'h002625242322}) begin
      errors++; $display("FAIL b2b_queue got %0d/%h want 5/002625242322", q_count, q_bytes);
    end
    checks++;
    if (head_ip !== 16'h0001) begin
      errors++; $display("FAIL b2b_head got %h want 0001", head_ip);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({q_count, cs_out, head_ip} !== {3'd0, 16'hFFFF, 16'h0000}) begin
      errors++; $display("FAIL rmid_state got %0d %h:%h want 0 FFFF:0000", q_count, cs_out, head_ip);
    end
    checks++;
    if ({rom_en, rom_addr} !== {1'b1, 20'hFFFF0}) begin
      errors++; $display("FAIL rmid_addr got %b/%h want 1/FFFF0", rom_en, rom_addr);
    end
    tick();
    #1;
    checks++;
    if (q_count !== 3'd0) begin
      errors++; $display("FAIL rmid_discard got %0d want 0", q_count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_consume();
    test_flush_pending();
    test_wrap();
    test_stall();
    test_bad_consume();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
